// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;

  localparam int unsigned WORD_W = 32;

  // Opcodes of the two instructions served by this interface.
  localparam logic [5:0] OP_LW = 6'b100011;
  localparam logic [5:0] OP_SW = 6'b101011;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_RESP
  } state_e;

  // Misaligned byte address, or word index beyond the end of the array.
  function automatic logic addr_err(input logic [WORD_W-1:0] addr, input int unsigned depth);
    logic [WORD_W-3:0] word;
    word = addr[WORD_W-1:2];
    return (addr[1:0] != 2'b00) || (word >= (WORD_W-2)'(depth));
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response channel pair between the load/store path and the responder.
interface dmem_responder_if;
  import dmem_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [WORD_W-1:0] req_addr;
  logic [WORD_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [WORD_W-1:0] rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/dmem_array.sv
// Single-port synchronous word RAM; read data registered, contents not reset.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH];

  // Write on enable+we; rdata only updates on an enabled access so it holds afterwards.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
      end
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Memory-side LW/SW responder: one request at a time, fixed latency, stallable response.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH   = 256,
  parameter int unsigned LATENCY = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  dmem_responder_if.slave bus
);

  localparam int unsigned AW       = $clog2(DEPTH);
  localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              we_q;
  logic [AW-1:0]     idx_q;
  logic [WORD_W-1:0] wdata_q;
  logic              err_q;
  logic              accept;
  logic              access;
  logic [WORD_W-1:0] ram_rdata;

  // Next-state and counter: IDLE -> BUSY (count down) -> RESP (wait for consumer) -> IDLE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    access  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        accept = bus.req_valid;
        if (accept) begin
          cnt_d   = CNT_INIT;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (cnt_q == 4'd0) begin
          access  = 1'b1;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        if (bus.rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and latency counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Capture the request on acceptance; later req_* values are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else if (accept) begin
      we_q    <= bus.req_we;
      idx_q   <= bus.req_addr[AW+1:2];
      wdata_q <= bus.req_wdata;
      err_q   <= addr_err(bus.req_addr, DEPTH);
    end
  end

  // Errored requests never touch the array.
  dmem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk   (clk),
    .en    (access && !err_q),
    .we    (access && we_q && !err_q),
    .addr  (idx_q),
    .wdata (wdata_q),
    .rdata (ram_rdata)
  );

  // Outputs are pure functions of state and captured request, so they hold during stalls.
  always_comb begin
    bus.req_ready = (state_q == ST_IDLE);
    bus.rsp_valid = (state_q == ST_RESP);
    bus.rsp_err   = (state_q == ST_RESP) && err_q;
    bus.rsp_rdata = ((state_q == ST_RESP) && !err_q && !we_q) ? ram_rdata : '0;
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed scenarios plus randomized traffic
// against an array model of the word memory.
module tb_dmem_responder;
  import dmem_pkg::*;

  localparam int unsigned DEPTH = 256;
  localparam int unsigned LAT   = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] model [DEPTH];

  dmem_responder_if m ();
  dmem_responder_if if1 ();
  dmem_responder_if if15 ();

  dmem_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (.clk(clk), .rst_n(rst_n), .bus(m));
  dmem_responder #(.DEPTH(DEPTH), .LATENCY(1)) u_l1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  dmem_responder #(.DEPTH(DEPTH), .LATENCY(15)) u_l15 (.clk(clk), .rst_n(rst_n), .bus(if15));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full transaction on the main DUT; lat = edges from acceptance to rsp_valid, -1 if never accepted.
  task automatic do_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rdata, output logic err, output int lat);
    int n;
    n = 0;
    lat = -1;
    rdata = 'x;
    err = 1'bx;
    while (m.req_ready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    if (m.req_ready !== 1'b1) return;
    m.req_valid = 1'b1;
    m.req_we    = we;
    m.req_addr  = addr;
    m.req_wdata = wdata;
    tick();
    m.req_valid = 1'b0;
    m.req_we    = 1'($urandom);
    m.req_addr  = $urandom;
    m.req_wdata = $urandom;
    lat = 0;
    while (m.rsp_valid !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
    rdata = m.rsp_rdata;
    err   = m.rsp_err;
    m.rsp_ready = 1'b1;
    tick();
    m.rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] rd, a_val;
    logic er;
    int lat;
    vectors++;
    if (m.req_ready !== 1'b1) begin
      miscompares++; $display("FAIL reset_req_ready: got %b want 1", m.req_ready);
    end
    vectors++;
    if (m.rsp_valid !== 1'b0) begin
      miscompares++; $display("FAIL reset_rsp_valid: got %b want 0", m.rsp_valid);
    end
    vectors++;
    if (m.rsp_rdata !== 32'h0) begin
      miscompares++; $display("FAIL reset_rsp_rdata: got %h want 0", m.rsp_rdata);
    end
    vectors++;
    if (m.rsp_err !== 1'b0) begin
      miscompares++; $display("FAIL reset_rsp_err: got %b want 0", m.rsp_err);
    end
    @(negedge clk) rst_n = 1'b1;
    tick();
    a_val = $urandom;
    do_txn(1'b1, 32'h20, a_val, rd, er, lat);
    model[8] = a_val;
    // Store accepted, then reset while it is still counting down.
    m.req_valid = 1'b1; m.req_we = 1'b1; m.req_addr = 32'h20; m.req_wdata = ~a_val;
    tick();
    m.req_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (m.req_ready !== 1'b1) begin
      miscompares++; $display("FAIL midbusy_req_ready: got %b want 1", m.req_ready);
    end
    vectors++;
    if (m.rsp_valid !== 1'b0) begin
      miscompares++; $display("FAIL midbusy_rsp_valid: got %b want 0", m.rsp_valid);
    end
    @(negedge clk) rst_n = 1'b1;
    tick();
    do_txn(1'b0, 32'h20, 32'h0, rd, er, lat);
    vectors++;
    if (rd !== model[8]) begin
      miscompares++; $display("FAIL midbusy_ram_kept: got %h want %h", rd, model[8]);
    end
  endtask

  task automatic test_store_load();
    logic [31:0] rd;
    logic er;
    int lat;
    do_txn(1'b1, 32'h10, 32'hDEADBEEF, rd, er, lat);
    model[4] = 32'hDEADBEEF;
    vectors++;
    if (lat != LAT || rd !== 32'h0 || er !== 1'b0) begin
      miscompares++; $display("FAIL sw_0x10: got lat %0d rdata %h err %b want lat %0d rdata 0 err 0",
                              lat, rd, er, LAT);
    end
    do_txn(1'b0, 32'h10, $urandom, rd, er, lat);
    vectors++;
    if (lat != LAT || rd !== 32'hDEADBEEF || er !== 1'b0) begin
      miscompares++;
      $display("FAIL lw_0x10: got lat %0d rdata %h err %b want lat %0d rdata deadbeef err 0",
               lat, rd, er, LAT);
    end
  endtask

  task automatic test_errors();
    logic [31:0] rd, x_val;
    logic er;
    int lat;
    x_val = $urandom;
    do_txn(1'b1, 32'h0, x_val, rd, er, lat);
    model[0] = x_val;
    do_txn(1'b0, 32'h13, 32'h0, rd, er, lat);
    vectors++;
    if (rd !== 32'h0 || er !== 1'b1 || lat != LAT) begin
      miscompares++; $display("FAIL lw_misaligned: got rdata %h err %b lat %0d want 0 1 %0d",
                              rd, er, lat, LAT);
    end
    // 0x400 aliases word 0 in the low index bits; it must not write it.
    do_txn(1'b1, 32'h400, ~x_val, rd, er, lat);
    vectors++;
    if (rd !== 32'h0 || er !== 1'b1) begin
      miscompares++; $display("FAIL sw_out_of_range: got rdata %h err %b want 0 1", rd, er);
    end
    do_txn(1'b0, 32'h0, 32'h0, rd, er, lat);
    vectors++;
    if (rd !== x_val || er !== 1'b0) begin
      miscompares++; $display("FAIL lw_after_err: got rdata %h err %b want %h 0", rd, er, x_val);
    end
  endtask

  task automatic test_backpressure();
    int lat;
    vectors++;
    if (m.req_ready !== 1'b1) begin
      miscompares++; $display("FAIL bp_idle_ready: got %b want 1", m.req_ready);
    end
    m.req_valid = 1'b1; m.req_we = 1'b0; m.req_addr = 32'h10; m.req_wdata = $urandom;
    tick();
    // Keep offering junk requests; none may be taken while the response is pending.
    m.req_we = 1'b1; m.req_addr = 32'h10; m.req_wdata = $urandom;
    lat = 0;
    while (m.rsp_valid !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
    vectors++;
    if (lat != LAT) begin
      miscompares++; $display("FAIL bp_latency: got %0d want %0d", lat, LAT);
    end
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if (m.rsp_valid !== 1'b1 || m.rsp_rdata !== model[4] || m.req_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL bp_hold_%0d: got valid %b rdata %h ready %b want 1 %h 0",
                 i, m.rsp_valid, m.rsp_rdata, m.req_ready, model[4]);
      end
      tick();
    end
    m.rsp_ready = 1'b1;
    m.req_valid = 1'b0;
    #1;
    vectors++;
    if (m.req_ready !== 1'b0 || m.rsp_valid !== 1'b1) begin
      miscompares++; $display("FAIL bp_handshake_cycle: got ready %b valid %b want 0 1",
                              m.req_ready, m.rsp_valid);
    end
    tick();
    m.rsp_ready = 1'b0;
    vectors++;
    if (m.rsp_valid !== 1'b0 || m.req_ready !== 1'b1) begin
      miscompares++; $display("FAIL bp_release: got valid %b ready %b want 0 1",
                              m.rsp_valid, m.req_ready);
    end
  endtask

  task automatic test_random();
    logic [31:0] rd, addr, wd, exp_rd;
    logic er, we, exp_err;
    int lat;
    for (int i = 0; i < 16; i++) begin
      wd = $urandom;
      do_txn(1'b1, 32'(i) << 2, wd, rd, er, lat);
      model[i] = wd;
    end
    for (int n = 0; n < 80; n++) begin
      we = 1'($urandom);
      wd = $urandom;
      case ($urandom_range(0, 9))
        0:       addr = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(1, 3));
        1:       addr = (32'($urandom_range(0, 15)) << 2) + (32'($urandom_range(1, 4000)) << 10);
        default: addr = 32'($urandom_range(0, 15)) << 2;
      endcase
      exp_err = (addr % 4 != 0) || (addr / 4 >= DEPTH);
      exp_rd  = (exp_err || we) ? 32'h0 : model[addr / 4];
      do_txn(we, addr, wd, rd, er, lat);
      if (we && !exp_err) model[addr / 4] = wd;
      vectors++;
      if (rd !== exp_rd || er !== exp_err || lat != LAT) begin
        miscompares++;
        $display("FAIL rand_%0d we %b addr %h: got rdata %h err %b lat %0d want %h %b %0d",
                 n, we, addr, rd, er, lat, exp_rd, exp_err, LAT);
      end
    end
  endtask

  // With req_valid and rsp_ready held high, each request spends LATENCY cycles in flight,
  // one cycle in RESP and one in IDLE before the next acceptance.
  task automatic test_back_to_back();
    int acc1[$];
    int acc15[$];
    int ncyc;
    bit a1, a15;
    ncyc = 100;
    if1.req_valid = 1'b1; if1.req_we = 1'b1; if1.req_addr = 32'h40;
    if1.req_wdata = $urandom; if1.rsp_ready = 1'b1;
    if15.req_valid = 1'b1; if15.req_we = 1'b1; if15.req_addr = 32'h40;
    if15.req_wdata = $urandom; if15.rsp_ready = 1'b1;
    for (int c = 1; c <= ncyc; c++) begin
      a1  = (if1.req_ready === 1'b1);
      a15 = (if15.req_ready === 1'b1);
      tick();
      if (a1) acc1.push_back(c);
      if (a15) acc15.push_back(c);
    end
    if1.req_valid = 1'b0;
    if15.req_valid = 1'b0;
    vectors++;
    if (acc1.size() != (ncyc - 1) / 3 + 1) begin
      miscompares++; $display("FAIL b2b_l1_count: got %0d want %0d", acc1.size(), (ncyc - 1) / 3 + 1);
    end
    vectors++;
    if (acc15.size() != (ncyc - 1) / 17 + 1) begin
      miscompares++;
      $display("FAIL b2b_l15_count: got %0d want %0d", acc15.size(), (ncyc - 1) / 17 + 1);
    end
    for (int i = 1; i < acc1.size(); i++) begin
      vectors++;
      if (acc1[i] - acc1[i-1] != 3) begin
        miscompares++; $display("FAIL b2b_l1_gap_%0d: got %0d want 3", i, acc1[i] - acc1[i-1]);
      end
    end
    for (int i = 1; i < acc15.size(); i++) begin
      vectors++;
      if (acc15[i] - acc15[i-1] != 17) begin
        miscompares++; $display("FAIL b2b_l15_gap_%0d: got %0d want 17", i, acc15[i] - acc15[i-1]);
      end
    end
  endtask

  initial begin
    m.req_valid = 1'b0; m.req_we = 1'b0; m.req_addr = '0; m.req_wdata = '0; m.rsp_ready = 1'b0;
    if1.req_valid = 1'b0; if1.req_we = 1'b0; if1.req_addr = '0; if1.req_wdata = '0;
    if1.rsp_ready = 1'b0;
    if15.req_valid = 1'b0; if15.req_we = 1'b0; if15.req_addr = '0; if15.req_wdata = '0;
    if15.rsp_ready = 1'b0;
    rst_n = 1'b0;
    #12;
    test_reset();
    test_store_load();
    test_errors();
    test_backpressure();
    test_random();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
